// File: rtl/toast_regfile_mp.sv
// Multi-port integer register file: NUM_RD_PORTS combinational reads, two write ports,
// sequential clear engine. Optional same-cycle forwarding under TOAST_REGFILE_BYPASS_EN.
module toast_regfile_mp #(
   parameter int REG_DATA_WIDTH     = 32,
   parameter int REGFILE_ADDR_WIDTH = 5,
   parameter int REGFILE_DEPTH      = 32,
   parameter int NUM_RD_PORTS       = 2
) (
   input  logic                                     clk_i,
   input  logic                                     reset_i,
   input  logic [NUM_RD_PORTS*REGFILE_ADDR_WIDTH-1:0] rs_addr_i,
   output logic [NUM_RD_PORTS*REG_DATA_WIDTH-1:0]     rs_data_o,
   input  logic [2*REGFILE_ADDR_WIDTH-1:0]           rd_addr_i,
   input  logic [2*REG_DATA_WIDTH-1:0]               rd_wr_data_i,
   input  logic [1:0]                                rd_wr_en_i,
   input  logic                                     clear_req_i,
   output logic                                     clear_busy_o,
   output logic                                     wr_conflict_o
);
   localparam int DW = REG_DATA_WIDTH;
   localparam int AW = REGFILE_ADDR_WIDTH;
   localparam logic [AW:0]   DEPTH_L = (AW+1)'(REGFILE_DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(REGFILE_DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state, state_nxt;
   logic [AW-1:0]       clr_idx, clr_idx_nxt;
   logic                conflict_nxt;
   logic [DW-1:0]       mem [REGFILE_DEPTH];
   logic [1:0][AW-1:0]  wa;
   logic [1:0][DW-1:0]  wd;
   logic [1:0]          wr_ok;

   function automatic logic in_rng(input logic [AW-1:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   assign wa = rd_addr_i;
   assign wd = rd_wr_data_i;

   // A clear request in READY drops the writes of that same cycle.
   always_comb begin
      for (int p = 0; p < 2; p++)
         wr_ok[p] = (state == READY) && !reset_i && !clear_req_i && rd_wr_en_i[p] &&
                    (wa[p] != '0) && in_rng(wa[p]);
   end

   assign conflict_nxt = (state == READY) && !clear_req_i && (&rd_wr_en_i) &&
                         (wa[0] == wa[1]) && (wa[0] != '0);

   always_comb begin
      state_nxt   = state;
      clr_idx_nxt = clr_idx;
      case (state)
         CLEAR: begin
            clr_idx_nxt = clr_idx + 1'b1;
            if (clr_idx == LAST) state_nxt = READY;
         end
         READY: begin
            if (clear_req_i) begin
               state_nxt   = CLEAR;
               clr_idx_nxt = AW'(1);
            end
         end
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state         <= CLEAR;
         clr_idx       <= AW'(1);
         wr_conflict_o <= 1'b0;
      end else begin
         state         <= state_nxt;
         clr_idx       <= clr_idx_nxt;
         wr_conflict_o <= conflict_nxt;
      end
   end

   // Array has no reset so it maps to LUT-RAM; port 1 is written last and wins.
   always_ff @(posedge clk_i) begin
      if (state == CLEAR) begin
         if (!reset_i) mem[clr_idx] <= '0;
      end else begin
         if (wr_ok[0]) mem[wa[0]] <= wd[0];
         if (wr_ok[1]) mem[wa[1]] <= wd[1];
      end
   end

   assign clear_busy_o = (state == CLEAR);

   for (genvar k = 0; k < NUM_RD_PORTS; k++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rdata;
      assign ra = rs_addr_i[k*AW +: AW];
      always_comb begin
         rdata = '0;
         if ((state == READY) && (ra != '0) && in_rng(ra)) begin
            rdata = mem[ra];
`ifdef TOAST_REGFILE_BYPASS_EN
            if (wr_ok[0] && (wa[0] == ra)) rdata = wd[0];
            if (wr_ok[1] && (wa[1] == ra)) rdata = wd[1];
`endif
         end
      end
      assign rs_data_o[k*DW +: DW] = rdata;
   end

endmodule

// File: tb/tb_toast_regfile_mp.sv
// Self-checking bench for toast_regfile_mp: table-driven writes with a scoreboard queue,
// plus hand sequences for clear latency, clear request and reset during clear.
module tb_toast_regfile_mp;
   localparam int NR = 4;
   localparam int DW = 32;
   localparam int AW = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic [NR*AW-1:0]    rs_addr;
   logic [NR*DW-1:0]    rs_data;
   logic [2*AW-1:0]     rd_addr;
   logic [2*DW-1:0]     rd_wr_data;
   logic [1:0]          rd_wr_en;
   logic                clear_req;
   logic                clear_busy;
   logic                wr_conflict;

   int tests = 0;
   int fails = 0;

   toast_regfile_mp #(.REG_DATA_WIDTH(DW), .REGFILE_ADDR_WIDTH(AW),
                      .REGFILE_DEPTH(32), .NUM_RD_PORTS(NR)) dut (
      .clk_i(clk), .reset_i(reset), .rs_addr_i(rs_addr), .rs_data_o(rs_data),
      .rd_addr_i(rd_addr), .rd_wr_data_i(rd_wr_data), .rd_wr_en_i(rd_wr_en),
      .clear_req_i(clear_req), .clear_busy_o(clear_busy), .wr_conflict_o(wr_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  a0;
      logic [31:0] d0;
      logic [4:0]  a1;
      logic [31:0] d1;
      logic [4:0]  c0;
      logic [31:0] e0;
      logic [4:0]  c1;
      logic [31:0] e1;
      logic        conf;
   } vec_t;

   vec_t vt[10];
   vec_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rd(input int k, input logic [4:0] a);
      rs_addr[k*AW +: AW] = a;
   endtask

   function automatic logic [31:0] rdata(input int k);
      return rs_data[k*DW +: DW];
   endfunction

   task automatic drive_wr(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                           input logic [4:0] a1, input logic [31:0] d1);
      rd_wr_en   = we;
      rd_addr    = {a1, a0};
      rd_wr_data = {d1, d0};
   endtask

   task automatic check_all_zero(input string nm);
      for (int a = 1; a < 32; a++) begin
         set_rd(a % NR, 5'(a));
         #1;
         chk($sformatf("%s addr %0d", nm, a), rdata(a % NR), 32'h0);
      end
   endtask

   initial begin
      int n;
      vec_t e;
      vt[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 5'd0,  32'h0,  1'b0};
      vt[1] = '{2'b01, 5'd0,  32'h00001234, 5'd0,  32'h0,        5'd0,  32'h0,        5'd5,  32'hDEADBEEF, 1'b0};
      vt[2] = '{2'b11, 5'd7,  32'h11,       5'd7,  32'h22,       5'd7,  32'h22,       5'd5,  32'hDEADBEEF, 1'b1};
      vt[3] = '{2'b11, 5'd7,  32'h33,       5'd8,  32'h44,       5'd7,  32'h33,       5'd8,  32'h44, 1'b0};
      vt[4] = '{2'b00, 5'd5,  32'h0000FFFF, 5'd8,  32'h1,        5'd5,  32'hDEADBEEF, 5'd8,  32'h44, 1'b0};
      vt[5] = '{2'b11, 5'd0,  32'h1,        5'd0,  32'h2,        5'd0,  32'h0,        5'd7,  32'h33, 1'b0};
      vt[6] = '{2'b10, 5'd3,  32'h9,        5'd31, 32'hCAFEF00D, 5'd31, 32'hCAFEF00D, 5'd30, 32'h0,  1'b0};
      vt[7] = '{2'b11, 5'd12, 32'h1,        5'd12, 32'h2,        5'd12, 32'h2,        5'd3,  32'h0,  1'b1};
      vt[8] = '{2'b00, 5'd12, 32'h5,        5'd12, 32'h6,        5'd12, 32'h2,        5'd7,  32'h33, 1'b0};
      vt[9] = '{2'b11, 5'd31, 32'h55,       5'd30, 32'h66,       5'd31, 32'h55,       5'd30, 32'h66, 1'b0};

      reset = 1'b1; clear_req = 1'b0; rs_addr = '0;
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      set_rd(0, 5'd5);

      // Reset state
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("reset busy c%0d", c), 32'(clear_busy), 32'h1);
         chk($sformatf("reset conflict c%0d", c), 32'(wr_conflict), 32'h0);
         chk($sformatf("reset rdata c%0d", c), rdata(0), 32'h0);
      end
      reset = 1'b0;
      n = 0;
      while (clear_busy && n < 100) begin tick(); n++; end
      chk("post-reset busy cycles", 32'(n), 32'd31);
      check_all_zero("post-reset zero");

      // Table-driven writes, expectations through the scoreboard queue
      for (int i = 0; i < 10; i++) begin
         drive_wr(vt[i].we, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1);
         sbq.push_back(vt[i]);
         tick();
         drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
         e = sbq.pop_front();
         set_rd(0, e.c0);
         set_rd(1, e.c1);
         #1;
         chk($sformatf("vec%0d port0 addr %0d", i, e.c0), rdata(0), e.e0);
         chk($sformatf("vec%0d port1 addr %0d", i, e.c1), rdata(1), e.e1);
         chk($sformatf("vec%0d conflict", i), 32'(wr_conflict), 32'(e.conf));
      end

      // Same-cycle write/read of addr 9
      set_rd(2, 5'd9);
      drive_wr(2'b01, 5'd9, 32'hA5A5A5A5, 5'd0, 32'h0);
      #1;
`ifdef TOAST_REGFILE_BYPASS_EN
      chk("bypass same cycle", rdata(2), 32'hA5A5A5A5);
`else
      chk("no-bypass same cycle", rdata(2), 32'h0);
`endif
      tick();
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      chk("write visible next cycle", rdata(2), 32'hA5A5A5A5);

      // Load all entries, then clear on request
      for (int a = 1; a < 32; a += 2) begin
         if (a < 31) drive_wr(2'b11, 5'(a), 32'h10000000 | a, 5'(a+1), 32'h10000000 | (a+1));
         else        drive_wr(2'b01, 5'(a), 32'h10000000 | a, 5'd0, 32'h0);
         tick();
      end
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      set_rd(3, 5'd17);
      #1;
      chk("loaded addr 17", rdata(3), 32'h10000011);
      clear_req = 1'b1;
      drive_wr(2'b11, 5'd3, 32'hFFFFFFFF, 5'd4, 32'hFFFFFFFF);
      tick();
      clear_req = 1'b0;
      n = 0;
      while (clear_busy && n < 100) begin
         drive_wr(2'b11, 5'((n % 31) + 1), 32'hBAD0BAD0, 5'(((n + 7) % 31) + 1), 32'hBAD1BAD1);
         clear_req = (n == 10);
         if (n == 5) chk("read during clear", rdata(3), 32'h0);
         tick();
         n++;
      end
      clear_req = 1'b0;
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      chk("clear_req busy cycles", 32'(n), 32'd31);
      check_all_zero("post-clear zero");

      // Reset mid-clear restarts the engine
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      repeat (9) tick();
      reset = 1'b1;
      repeat (2) tick();
      chk("busy during mid-clear reset", 32'(clear_busy), 32'h1);
      reset = 1'b0;
      n = 0;
      while (clear_busy && n < 100) begin tick(); n++; end
      chk("restart busy cycles", 32'(n), 32'd31);

      drive_wr(2'b01, 5'd2, 32'h77, 5'd0, 32'h0);
      tick();
      drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      set_rd(1, 5'd2);
      #1;
      chk("write after restart", rdata(1), 32'h77);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
